// File: rtl/line_buffer_15rows_if.sv
// line_buffer_15rows_if
//   Pixel-stream and column-tap bundle for line_buffer_15rows.
//   done_i/data_i      : raster-order pixel input (valid + data)
//   S1_o..S15_o        : vertically aligned column taps, S1_o oldest row
//   done_o             : taps valid
//   frame_done_o       : one-cycle end-of-frame pulse
//   master modport drives the pixel stream; slave modport is the line buffer.
interface line_buffer_15rows_if #(
  parameter int DATA_W = 8
);
  logic              done_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] S1_o,  S2_o,  S3_o,  S4_o,  S5_o;
  logic [DATA_W-1:0] S6_o,  S7_o,  S8_o,  S9_o,  S10_o;
  logic [DATA_W-1:0] S11_o, S12_o, S13_o, S14_o, S15_o;
  logic              done_o;
  logic              frame_done_o;

  modport master (
    output done_i, data_i,
    input  S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o,
           S9_o, S10_o, S11_o, S12_o, S13_o, S14_o, S15_o,
           done_o, frame_done_o
  );

  modport slave (
    input  done_i, data_i,
    output S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o,
           S9_o, S10_o, S11_o, S12_o, S13_o, S14_o, S15_o,
           done_o, frame_done_o
  );
endinterface

// File: rtl/line_buffer_15rows.sv
// line_buffer_15rows
//   Stores the 14 previous rows of a raster pixel stream and presents the
//   15 vertically aligned pixels of the column just accepted, registered
//   with one cycle of latency.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (counters, state, outputs;
//           row memory is not cleared)
//   bus   : line_buffer_15rows_if.slave (done_i, data_i in; S1_o..S15_o,
//           done_o, frame_done_o out)
// Build option:
//   LINE_BUFFER_TOP_PAD_EN - rows above the top of the frame read as zero
//   and done_o follows done_i from row 0 onward.
module line_buffer_15rows #(
  parameter int COLS   = 17,
  parameter int ROWS   = 17,
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  line_buffer_15rows_if.slave bus
);
  localparam int COL_W    = $clog2(COLS);
  localparam int ROW_W    = $clog2(ROWS);
  localparam int MEM_ROWS = 14;
  localparam int TAPS     = 15;

  typedef enum logic {FILL, STREAM} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [3:0]        wr_row_q, wr_row_d;
  logic [DATA_W-1:0] taps_q [TAPS];
  logic [DATA_W-1:0] taps_d [TAPS];
  logic              done_q, done_d;
  logic              frame_done_q, frame_done_d;

  logic [DATA_W-1:0] row_mem_q [MEM_ROWS][COLS];

  logic              last_col, last_row, mem_we, stream_px;
  logic [4:0]        slot;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wr_row_d     = wr_row_q;
    taps_d       = taps_q;
    done_d       = 1'b0;
    frame_done_d = 1'b0;
    mem_we       = 1'b0;
    stream_px    = 1'b0;
    slot         = '0;
    last_col     = (col_q == COL_W'(COLS - 1));
    last_row     = (row_q == ROW_W'(ROWS - 1));

    if (bus.done_i) begin
      mem_we = 1'b1;
      // Slot wr_row_q still holds row r-14 (read before overwrite); the
      // following slots hold progressively newer rows up to r-1.
      for (int unsigned j = 0; j < MEM_ROWS; j++) begin
        slot = 5'(wr_row_q) + 5'(j);
        if (slot >= 5'(MEM_ROWS)) slot = slot - 5'(MEM_ROWS);
        taps_d[j] = row_mem_q[slot[3:0]][col_q];
`ifdef LINE_BUFFER_TOP_PAD_EN
        if ((32'(row_q) + j) < 32'(MEM_ROWS)) taps_d[j] = '0;
`endif
      end
      taps_d[TAPS-1] = bus.data_i;

      if (last_col) begin
        col_d    = '0;
        wr_row_d = (wr_row_q == 4'(MEM_ROWS - 1)) ? '0 : wr_row_q + 4'd1;
        row_d    = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d    = col_q + 1'b1;
      end

      case (state_q)
        FILL: begin
          if (row_q == ROW_W'(MEM_ROWS) && col_q == '0) begin
            state_d   = STREAM;
            stream_px = 1'b1;
          end
        end
        STREAM: begin
          stream_px = 1'b1;
          if (last_row && last_col) state_d = FILL;
        end
        default: state_d = FILL;
      endcase

`ifdef LINE_BUFFER_TOP_PAD_EN
      done_d = 1'b1;
`else
      done_d = stream_px;
`endif
      frame_done_d = last_row && last_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      wr_row_q     <= '0;
      taps_q       <= '{default: '0};
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_row_q     <= wr_row_d;
      taps_q       <= taps_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) row_mem_q[wr_row_q][col_q] <= bus.data_i;
  end

  assign bus.S1_o         = taps_q[0];
  assign bus.S2_o         = taps_q[1];
  assign bus.S3_o         = taps_q[2];
  assign bus.S4_o         = taps_q[3];
  assign bus.S5_o         = taps_q[4];
  assign bus.S6_o         = taps_q[5];
  assign bus.S7_o         = taps_q[6];
  assign bus.S8_o         = taps_q[7];
  assign bus.S9_o         = taps_q[8];
  assign bus.S10_o        = taps_q[9];
  assign bus.S11_o        = taps_q[10];
  assign bus.S12_o        = taps_q[11];
  assign bus.S13_o        = taps_q[12];
  assign bus.S14_o        = taps_q[13];
  assign bus.S15_o        = taps_q[14];
  assign bus.done_o       = done_q;
  assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_line_buffer_15rows.sv
// tb_line_buffer_15rows
//   Directed vector bench for line_buffer_15rows (COLS=ROWS=17): reset,
//   fill, stall mid-row, back-to-back frames, reset mid-frame, and the
//   top-padding build when LINE_BUFFER_TOP_PAD_EN is defined.
module tb_line_buffer_15rows;
  localparam int COLS      = 17;
  localparam int ROWS      = 17;
  localparam int DATA_W    = 8;
  localparam int FILL_PIX  = 14 * COLS;
  localparam int FRAME_PIX = ROWS * COLS;
`ifdef LINE_BUFFER_TOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int DONE_PER_FRAME = PAD ? FRAME_PIX : (ROWS - 14) * COLS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_buffer_15rows_if #(.DATA_W(DATA_W)) bus ();

  line_buffer_15rows #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] taps [15];
  assign taps[0]  = bus.S1_o;
  assign taps[1]  = bus.S2_o;
  assign taps[2]  = bus.S3_o;
  assign taps[3]  = bus.S4_o;
  assign taps[4]  = bus.S5_o;
  assign taps[5]  = bus.S6_o;
  assign taps[6]  = bus.S7_o;
  assign taps[7]  = bus.S8_o;
  assign taps[8]  = bus.S9_o;
  assign taps[9]  = bus.S10_o;
  assign taps[10] = bus.S11_o;
  assign taps[11] = bus.S12_o;
  assign taps[12] = bus.S13_o;
  assign taps[13] = bus.S14_o;
  assign taps[14] = bus.S15_o;

  typedef struct {
    logic             rst;
    logic             done;
    logic [7:0]       data;
    logic             exp_done;
    logic             exp_fd;
    logic             chk_taps;
    logic [14:0][7:0] exp_tap;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at vector %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Tap x (1..15) after accepting frame pixel k shows pixel k-COLS*(15-x).
  function automatic logic [7:0] tap_val(input int k, input int x);
    int kk;
    kk = k - COLS * (15 - x);
    return (kk < 0) ? 8'd0 : 8'(kk % 256);
  endfunction

  function automatic vec_t pix_vec(input int k);
    vec_t v;
    v.rst      = 1'b0;
    v.done     = 1'b1;
    v.data     = 8'(k % 256);
    v.exp_done = PAD ? 1'b1 : (k >= FILL_PIX);
    v.exp_fd   = (k == FRAME_PIX - 1);
    v.chk_taps = PAD ? 1'b1 : (k >= FILL_PIX);
    for (int x = 1; x <= 15; x++) v.exp_tap[x-1] = tap_val(k, x);
    return v;
  endfunction

  function automatic vec_t hold_vec(input vec_t prev);
    vec_t v;
    v          = prev;
    v.done     = 1'b0;
    v.rst      = 1'b0;
    v.data     = 8'hEE;
    v.exp_done = 1'b0;
    v.exp_fd   = 1'b0;
    return v;
  endfunction

  function automatic vec_t rst_vec();
    vec_t v;
    v.rst      = 1'b1;
    v.done     = 1'b1;
    v.data     = 8'hAA;
    v.exp_done = 1'b0;
    v.exp_fd   = 1'b0;
    v.chk_taps = 1'b1;
    v.exp_tap  = '0;
    return v;
  endfunction

  initial begin
    int done_cnt;
    vec_t v;

    bus.done_i = 1'b0;
    bus.data_i = '0;

    // Vector table: reset, frame 1 with a 3-cycle stall after k=245,
    // frame 2 back-to-back, partial frame 3 cut by reset (done_i also high),
    // full frame 4 after the reset, then idle cycles.
    vecs.push_back(rst_vec());
    for (int k = 0; k < FRAME_PIX; k++) begin
      vecs.push_back(pix_vec(k));
      if (k == 245) for (int s = 0; s < 3; s++) vecs.push_back(hold_vec(vecs[vecs.size()-1]));
    end
    for (int k = 0; k < FRAME_PIX; k++) vecs.push_back(pix_vec(k));
    for (int k = 0; k <= 250; k++) vecs.push_back(pix_vec(k));
    vecs.push_back(rst_vec());
    for (int k = 0; k < FRAME_PIX; k++) vecs.push_back(pix_vec(k));
    for (int s = 0; s < 2; s++) vecs.push_back(hold_vec(vecs[vecs.size()-1]));

    done_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      rst        = v.rst;
      bus.done_i = v.done;
      bus.data_i = v.data;
      @(posedge clk);
      #1;
      check("done_o", i, 32'(bus.done_o), 32'(v.exp_done));
      check("frame_done_o", i, 32'(bus.frame_done_o), 32'(v.exp_fd));
      if (v.chk_taps)
        for (int x = 0; x < 15; x++)
          check($sformatf("S%0d_o", x + 1), i, 32'(taps[x]), 32'(v.exp_tap[x]));
      if (v.rst) done_cnt = 0;
      else if (bus.done_o === 1'b1) done_cnt++;
      if (v.exp_fd) begin
        check("done_count", i, 32'(done_cnt), 32'(DONE_PER_FRAME));
        done_cnt = 0;
      end
    end

    // Hand sequence: reset with done_i low, idle cycles must not disturb
    // outputs, then the first pixel of a fresh frame.
    @(negedge clk);
    rst = 1'b1; bus.done_i = 1'b0;
    @(posedge clk); #1;
    check("rst_idle_done_o", 0, 32'(bus.done_o), 32'd0);
    check("rst_idle_S15_o", 0, 32'(bus.S15_o), 32'd0);
    check("rst_idle_S1_o", 0, 32'(bus.S1_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_done_o", 1, 32'(bus.done_o), 32'd0);
    check("idle_S15_o", 1, 32'(bus.S15_o), 32'd0);
    check("idle_frame_done_o", 1, 32'(bus.frame_done_o), 32'd0);
    @(negedge clk);
    bus.done_i = 1'b1; bus.data_i = 8'h5A;
    @(posedge clk); #1;
    check("first_px_done_o", 2, 32'(bus.done_o), 32'(PAD));
    check("first_px_frame_done_o", 2, 32'(bus.frame_done_o), 32'd0);
    if (PAD) check("first_px_S15_o", 2, 32'(bus.S15_o), 32'h5A);
    @(negedge clk);
    bus.done_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/line_buffer_15rows.md
Name: line_buffer_15rows

Overview:
- Upstream feeder for the 15x15 window buffer stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per cycle when done_i is high.
- Stores the 14 previous image rows internally.
- Emits 15 vertically aligned pixels, one per row tap S1_o..S15_o, for the same column.
- Flags when the vertical neighbourhood is fully populated, and pulses at end of frame.

Parameters:
- COLS, 17, pixels per row; each internal row memory is COLS deep; must be at least 2.
- ROWS, 17, rows per frame; must be at least 15.
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- done_i  input  1  pixel valid; data_i is accepted on every rising edge where done_i=1.
- data_i  input  DATA_W  incoming pixel, raster order.
- S1_o..S15_o  output  DATA_W each  column taps; S1_o is the oldest row (r-14), S15_o is the current row r.
- done_o  output  1  taps valid; the next-stage window buffer uses this as its done_i.
- frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0.
  - col_cnt, row_cnt and the row-write pointer go to 0.
  - State goes to FILL.
  - Row memory contents are not cleared.
- Counters:
  - col_cnt runs 0..COLS-1 and advances only on an accepted pixel.
  - When col_cnt wraps, row_cnt increments, and the memory rotation advances by one row.
  - row_cnt runs 0..ROWS-1.
- Storage:
  - 14 row memories, each COLS entries of DATA_W bits, arranged as a circular set of rows.
  - Implementation may use shift registers or RAM plus a rotating row pointer.
  - Only the indexing is prescribed: S(15-k)_o is the pixel at (row_cnt-k, col_cnt) for k=0..14.
- Latency and stalls:
  - All outputs are registered, with exactly 1 cycle latency from acceptance.
  - On a cycle with done_i=1, the S taps update to the column just accepted.
  - On a cycle with done_i=0, S1_o..S15_o hold their values, done_o is 0, and no counter or memory changes.
- State machine:
  - FILL: entered on reset or end of frame. Moves to STREAM when a pixel is accepted with row_cnt=14 and col_cnt=0.
  - STREAM: while here, done_o equals done_i delayed by 1 cycle.
  - End of frame: a pixel accepted at row_cnt=ROWS-1, col_cnt=COLS-1 does three things:
    - it is output normally, with done_o=1 on the next cycle;
    - frame_done_o pulses on that same next cycle;
    - counters return to 0 and the state returns to FILL.
  - In FILL, done_o=0 while taps still update, unless the optional feature is enabled.
- Boundaries:
  - done_o=1 occurs exactly (ROWS-14)*COLS times per frame.
  - Back-to-back frames need no idle cycles; the first pixel of the next frame may arrive on the cycle after the last pixel of the previous one.
  - rst has priority over done_i on the same edge.
  - Reset mid-frame discards the partial frame; the next frame must refill 14 rows.
  - Arithmetic is unsigned.
  - Counter widths are clog2 of COLS and clog2 of ROWS.
  - No saturation is needed: the wraps are explicit compares.

Optional Feature:
- Macro: LINE_BUFFER_TOP_PAD_EN.
- Defined:
  - Top zero padding is applied.
  - done_o follows done_i from row 0 onward.
  - Any tap whose source row is row_cnt-k<0 outputs 0 instead of stale memory.
  - done_o=1 occurs ROWS*COLS times per frame.
- Undefined:
  - done_o is gated by FILL as described above.
  - Tap values during FILL are don't-care.

Test Plan:
1. Reset then fill:
   - Stimulus: rst for 1 cycle; then a continuous stream, data_i = k mod 256 for k=0..288, with COLS=ROWS=17.
   - Response: done_o stays 0 through k=237. First done_o=1 occurs on the cycle after k=238, with S15_o=238, S14_o=221, S1_o=0.
2. Frame end:
   - Stimulus: continue scenario 1 through k=288.
   - Response: the final tap set is S15_o=32 (288 mod 256) and S1_o=50. frame_done_o=1 for exactly that one cycle. The total done_o count is 51.
3. Stall mid-row:
   - Stimulus: deassert done_i for 3 cycles after k=245, then resume.
   - Response: done_o=0 for 3 cycles and taps hold at S15_o=245. After resuming, the next output is S15_o=246, S1_o=8 (column 8 of row 0), with no skipped or duplicated column.
4. Back-to-back frames:
   - Stimulus: a second frame immediately follows k=288, restarting at k=0.
   - Response: done_o=0 for the first 238 pixels of frame 2, then reasserts with S15_o=238.
5. Reset mid-frame:
   - Stimulus: rst pulsed after k=250.
   - Response: all outputs are 0 the next cycle. A new frame needs 238 pixels before done_o asserts.
6. With LINE_BUFFER_TOP_PAD_EN defined:
   - Stimulus: scenario 1 stimulus.
   - Response: done_o=1 from the cycle after k=0, with S15_o=0 and S1_o..S14_o=0. On the cycle after k=20 (row 1, col 3): S15_o=20, S14_o=3, S1_o..S13_o=0.
